alu_cmd_sequencer: RTL and testbench

Initiator side of the ALU operand/result interface. It accepts ALU commands (A, B, select) over a valid/ready handshake and buffers them in a small FIFO. It drives them one at a time onto registered A/B/ALU_Sel lines feeding the combinational ALU, waits a fixed settle time, then captures ALU_Out, coutfin and z into a result register offered on a valid/ready output. It replaces free-running stimulus with a flow-controlled issuer usable by the datapath and by benches.

---
 rtl/alu_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Flow-controlled issuer for a combinational ALU: command FIFO, settle timer, held result register.
// Optional build macro ALU_SEQ_STATS_EN adds op_count/zero_count capture counters.
module alu_cmd_sequencer #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_z,
  output logic             busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]      op_count,
  output logic [15:0]      zero_count
`endif
);

  // state  | meaning
  // IDLE   | waiting for a queued command; ALU inputs hold last values
  // SETTLE | ALU inputs driven, counting down until alu_out is trusted
  // HOLD   | result captured, waiting for res_ready
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int EW = 2 * WIDTH + 4;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             push, pop, empty, full, capture;
  logic [EW-1:0]    head;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_cout_q, res_cout_d, res_z_q, res_z_d;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign capture   = (state_q == S_SETTLE) && (cnt_q == '0);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_sel, cmd_b, cmd_a};
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cout_d  = res_cout_q;
    res_z_d     = res_z_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          {alu_sel_d, alu_b_d, alu_a_d} = head;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (capture) begin
          res_data_d  = alu_out;
          res_cout_d  = alu_cout;
          res_z_d     = alu_z;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
      res_z_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cout_q  <= res_cout_d;
      res_z_q     <= res_z_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;
  assign res_z     = res_z_q;
  assign busy      = (state_q != S_IDLE) || !empty;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_cnt_q, zero_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q   <= '0;
      zero_cnt_q <= '0;
    end else if (capture) begin
      op_cnt_q <= op_cnt_q + 16'd1;
      if (alu_z) zero_cnt_q <= zero_cnt_q + 16'd1;
    end
  end

  assign op_count   = op_cnt_q;
  assign zero_count = zero_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: adder stub on the ALU ports, transaction-level model compared every
// cycle, directed scenarios with literal expectations, and a SETTLE_CYCLES=3 instance.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_valid, cmd_ready, res_valid, res_ready, res_cout, res_z, busy;
  logic [WIDTH-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, res_data;
  logic [3:0]       cmd_sel, alu_sel;
  logic             alu_cout, alu_z;
  logic [WIDTH:0]   stub_sum;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]      op_count, zero_count, op_count3, zero_count3;
`endif

  assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out  = stub_sum[WIDTH-1:0];
  assign alu_cout = stub_sum[WIDTH];
  assign alu_z    = (stub_sum[WIDTH-1:0] == '0);

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_z(res_z), .busy(busy)
`ifdef ALU_SEQ_STATS_EN
    , .op_count(op_count), .zero_count(zero_count)
`endif
  );

  logic             cmd_valid3, cmd_ready3, res_valid3, res_ready3, res_cout3, res_z3, busy3;
  logic [WIDTH-1:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_out3, res_data3;
  logic [3:0]       cmd_sel3, alu_sel3;
  logic             alu_cout3, alu_z3;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_sel(cmd_sel3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
    .alu_out(alu_out3), .alu_cout(alu_cout3), .alu_z(alu_z3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_cout(res_cout3), .res_z(res_z3), .busy(busy3)
`ifdef ALU_SEQ_STATS_EN
    , .op_count(op_count3), .zero_count(zero_count3)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: queue of accepted commands, one command in service at a time.
  cmd_t             m_q[$];
  cmd_t             m_cur;
  logic             m_run = 1'b0, m_pend = 1'b0, m_acc;
  int               m_left = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]       m_sel = '0;
  logic             m_cout = 1'b0, m_z = 1'b0;
  logic [15:0]      m_ops = '0, m_zeros = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_run = 1'b0; m_pend = 1'b0; m_left = 0;
      m_a = '0; m_b = '0; m_sel = '0; m_res = '0; m_cout = 1'b0; m_z = 1'b0;
      m_ops = '0; m_zeros = '0;
    end else begin
      m_acc = cmd_valid && (m_q.size() < DEPTH);
      if (m_pend) begin
        if (res_ready) m_pend = 1'b0;
      end else if (m_run) begin
        if (m_left == 0) begin
          {m_cout, m_res} = {1'b0, m_a} + {1'b0, m_b};
          m_z    = (m_res == '0);
          m_pend = 1'b1;
          m_run  = 1'b0;
          m_ops  = m_ops + 16'd1;
          if (m_z) m_zeros = m_zeros + 16'd1;
        end else begin
          m_left = m_left - 1;
        end
      end else if (m_q.size() > 0) begin
        m_cur  = m_q.pop_front();
        m_a    = m_cur.a; m_b = m_cur.b; m_sel = m_cur.sel;
        m_run  = 1'b1;
        m_left = SETTLE - 1;
      end
      if (m_acc) begin
        m_cur.a = cmd_a; m_cur.b = cmd_b; m_cur.sel = cmd_sel;
        m_q.push_back(m_cur);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("res_valid", res_valid, m_pend);
    if (m_pend) begin
      chk("res_data", res_data, m_res);
      chk("res_cout", res_cout, m_cout);
      chk("res_z", res_z, m_z);
    end
    chk("cmd_ready", cmd_ready, m_q.size() < DEPTH);
    chk("busy", busy, m_run || m_pend || (m_q.size() > 0));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sel", alu_sel, m_sel);
`ifdef ALU_SEQ_STATS_EN
    chk("op_count", op_count, m_ops);
    chk("zero_count", zero_count, m_zeros);
`endif
  end

  logic [WIDTH-1:0] got_q[$];
  initial forever begin
    @(negedge clk);
    if (rst_n && res_valid && res_ready) got_q.push_back(res_data);
  end

  // Command driver: holds each queued command on the bus until the edge that accepts it.
  cmd_t tx_q[$];
  logic rdy_prev = 1'b0;
  initial begin
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    forever begin
      @(posedge clk);
      if (cmd_valid && rdy_prev && rst_n && tx_q.size() > 0) void'(tx_q.pop_front());
      #2;
      if (tx_q.size() > 0) begin
        cmd_valid = 1'b1;
        cmd_a = tx_q[0].a; cmd_b = tx_q[0].b; cmd_sel = tx_q[0].sel;
      end else begin
        cmd_valid = 1'b0;
      end
      rdy_prev = cmd_ready;
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] sel);
    cmd_t c;
    c.a = a; c.b = b; c.sel = sel;
    tx_q.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((tx_q.size() > 0 || busy || res_valid) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_drained"}, k < budget, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] ra, rb;

  initial begin
    res_ready  = 1'b1;
    cmd_valid3 = 1'b0; cmd_a3 = '0; cmd_b3 = '0; cmd_sel3 = '0;
    res_ready3 = 1'b0; alu_out3 = '0; alu_cout3 = 1'b0; alu_z3 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_sel", alu_sel, 4'h0);
    chk("rst_res_data", res_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);

    // single op: issue one edge after acceptance, result one edge later
    send(32'hABCDEFFF, 32'h12345678, 4'b0010);
    step(2);
    chk("single_alu_sel", alu_sel, 4'b0010);
    chk("single_alu_a", alu_a, 32'hABCDEFFF);
    chk("single_early_valid", res_valid, 1'b0);
    step(1);
    chk("single_valid", res_valid, 1'b1);
    chk("single_data", res_data, 32'hBE024677);
    chk("single_cout", res_cout, 1'b0);
    chk("single_z", res_z, 1'b0);
    wait_idle("single", 20);

    send(32'hFFFFFFFF, 32'h00000001, 4'h0);
    step(3);
    chk("zc_data", res_data, 32'h0);
    chk("zc_cout", res_cout, 1'b1);
    chk("zc_z", res_z, 1'b1);
`ifdef ALU_SEQ_STATS_EN
    chk("zc_op_count", op_count, 16'd2);
    chk("zc_zero_count", zero_count, 16'd1);
`endif
    wait_idle("zc", 20);

    // backpressure: first result held, FIFO fills, sixth command stalls
    got_q.delete();
    res_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(WIDTH'(k), WIDTH'(k), 4'(k));
    step(8);
    chk("bp_cmd_ready", cmd_ready, 1'b0);
    chk("bp_valid", res_valid, 1'b1);
    chk("bp_data", res_data, 32'h2);
    chk("bp_stalled", tx_q.size(), 1);
    step(2);
    chk("bp_data_stable", res_data, 32'h2);
    res_ready = 1'b1;
    wait_idle("bp", 60);
    chk("bp_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("bp_result%0d", i), got_q[i], WIDTH'(2 * (i + 1)));

    // simultaneous push and pop on the issue edge
    got_q.delete();
    res_ready = 1'b0;
    send(32'd100, 32'd200, 4'h1);
    begin
      int k;
      k = 0;
      while (!res_valid && k < 20) begin step(1); k++; end
      chk("pp_first_valid", res_valid, 1'b1);
    end
    send(32'd300, 32'd400, 4'h2);
    step(2);
    chk("pp_held", res_valid, 1'b1);
    chk("pp_b_accepted", tx_q.size(), 0);
    res_ready = 1'b1;
    step(1);
    send(32'd500, 32'd600, 4'h3);
    step(1);
    chk("pp_issue_b", alu_a, 32'd300);
    chk("pp_cmd_ready", cmd_ready, 1'b1);
    chk("pp_busy", busy, 1'b1);
    wait_idle("pp", 40);
    chk("pp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("pp_r0", got_q[0], 32'd300);
      chk("pp_r1", got_q[1], 32'd700);
      chk("pp_r2", got_q[2], 32'd1100);
    end

    // reset during SETTLE with three commands queued
    res_ready = 1'b1;
    for (int k = 1; k <= 5; k++) send(WIDTH'(16 * k), WIDTH'(k), 4'(k));
    step(5);
    chk("rm_busy", busy, 1'b1);
    chk("rm_in_settle", res_valid, 1'b0);
    chk("rm_alu_a", alu_a, 32'd32);
    chk("rm_all_accepted", tx_q.size(), 0);
    got_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("rm_res_valid", res_valid, 1'b0);
    chk("rm_alu_a0", alu_a, 32'h0);
    chk("rm_alu_b0", alu_b, 32'h0);
    chk("rm_alu_sel0", alu_sel, 4'h0);
    chk("rm_busy0", busy, 1'b0);
    chk("rm_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(10);
    chk("rm_no_stale", got_q.size(), 0);
    chk("rm_idle", busy, 1'b0);

    // randomized traffic with random backpressure, checked for order against the sends
    got_q.delete();
    exp_q.delete();
    for (int c = 0; c < 120; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom;
        rb = ($urandom_range(0, 4) == 0) ? -ra : $urandom;
        send(ra, rb, 4'($urandom_range(0, 15)));
        exp_q.push_back(ra + rb);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    res_ready = 1'b1;
    wait_idle("rnd", 400);
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_result%0d", i), got_q[i], exp_q[i]);

    // SETTLE_CYCLES=3 instance: only the alu_out present in the last SETTLE cycle is captured
    cmd_valid3 = 1'b1; cmd_a3 = 32'd11; cmd_b3 = 32'd22; cmd_sel3 = 4'h5;
    step(1);
    cmd_valid3 = 1'b0;
    alu_out3 = 32'hDEAD0001;
    chk("s3_e0_valid", res_valid3, 1'b0);
    step(1);
    chk("s3_alu_a", alu_a3, 32'd11);
    chk("s3_alu_sel", alu_sel3, 4'h5);
    alu_out3 = 32'hDEAD0002; alu_z3 = 1'b1;
    step(1);
    chk("s3_e2_valid", res_valid3, 1'b0);
    alu_out3 = 32'hDEAD0003;
    step(1);
    chk("s3_e3_valid", res_valid3, 1'b0);
    alu_out3 = 32'h00000777; alu_cout3 = 1'b1; alu_z3 = 1'b0;
    step(1);
    chk("s3_e4_valid", res_valid3, 1'b1);
    chk("s3_data", res_data3, 32'h777);
    chk("s3_cout", res_cout3, 1'b1);
    chk("s3_z", res_z3, 1'b0);
    alu_out3 = 32'hBAD0BAD0; alu_z3 = 1'b1;
    step(1);
    chk("s3_hold_data", res_data3, 32'h777);
    chk("s3_hold_valid", res_valid3, 1'b1);
    res_ready3 = 1'b1;
    step(1);
    chk("s3_done_valid", res_valid3, 1'b0);
    chk("s3_done_busy", busy3, 1'b0);
    chk("s3_cmd_ready", cmd_ready3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
